imm_extend_pipe: RTL and testbench

Registered, parametrised immediate generator for the LEGv8 decode stage. Decodes the opcode field of a 32-bit instruction, then extracts and extends the immediate for the D, CB, B, I and IW formats to `N` bits. It also reports the detected format. Results pass through a 2-entry valid/ready buffer so decode can stall without losing instructions, and illegal encodings are counted.

---
 rtl/imm_extend_pipe_if.sv | 27 ++
 rtl/imm_extend_pipe.sv | 161 ++++++++++++++++
 tb/tb_imm_extend_pipe.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle for imm_extend_pipe: instruction input side, buffered
// immediate output side, flush and the illegal-instruction counter.
interface imm_extend_pipe_if #(
  parameter int N     = 64,
  parameter int ERR_W = 8
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     imm;
  logic [2:0]       fmt;
  logic             illegal;
  logic [ERR_W-1:0] err_count;

  modport master (
    output flush, in_valid, instr, out_ready,
    input  in_ready, out_valid, imm, fmt, illegal, err_count
  );

  modport slave (
    input  flush, in_valid, instr, out_ready,
    output in_ready, out_valid, imm, fmt, illegal, err_count
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// LEGv8 immediate generator: decodes each instruction once at push and queues
// {imm, fmt} in a 2-entry shift FIFO whose head slot drives the outputs directly.
module imm_extend_pipe #(
  parameter int N            = 64,
  parameter bit SHIFT_BRANCH = 1'b1,
  parameter int ERR_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  imm_extend_pipe_if.slave bus
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_D    = 3'd1;
  localparam logic [2:0] FMT_CB   = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_I    = 3'd4;
  localparam logic [2:0] FMT_IW   = 3'd5;
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  typedef struct packed {
    logic         illegal;
    logic [2:0]   fmt;
    logic [N-1:0] imm;
  } entry_t;

  localparam entry_t EMPTY_ENTRY = '0;

  // Everything is built 64 bits wide and truncated last, so extension and
  // shift happen before any bits are dropped for N=32.
  function automatic entry_t decode(input logic [31:0] ins);
    logic [63:0] wide;
    logic [2:0]  f;
    entry_t      e;
    wide = 64'd0;
    f    = FMT_NONE;
    if ((ins[31:21] == 11'b11111000010) || (ins[31:21] == 11'b11111000000)) begin
      f    = FMT_D;
      wide = {{55{ins[20]}}, ins[20:12]};
    end else if (ins[31:25] == 7'b1011010) begin
      f    = FMT_CB;
      wide = {{45{ins[23]}}, ins[23:5]};
      if (SHIFT_BRANCH) begin
        wide = wide << 2;
      end else begin
        wide = wide;
      end
    end else if (ins[30:26] == 5'b00101) begin
      f    = FMT_B;
      wide = {{38{ins[25]}}, ins[25:0]};
      if (SHIFT_BRANCH) begin
        wide = wide << 2;
      end else begin
        wide = wide;
      end
    end else if ((ins[31:22] == 10'b1001000100) || (ins[31:22] == 10'b1101000100)) begin
      f    = FMT_I;
      wide = {52'd0, ins[21:10]};
    end else if (ins[31:23] == 9'b110100101) begin
      f    = FMT_IW;
      wide = {48'd0, ins[20:5]} << {ins[22:21], 4'b0000};
    end else begin
      f    = FMT_NONE;
      wide = 64'd0;
    end
    e.imm     = wide[N-1:0];
    e.fmt     = f;
    e.illegal = (f == FMT_NONE);
    return e;
  endfunction

  entry_t           head_q, head_d;
  entry_t           tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic [ERR_W-1:0] err_q, err_d;
  entry_t           new_s;
  logic             push_s;
  logic             pop_s;

  assign bus.in_ready  = !reset && !bus.flush && (count_q != 2'd2);
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.imm       = head_q.imm;
  assign bus.fmt       = head_q.fmt;
  assign bus.illegal   = head_q.illegal;
  assign bus.err_count = err_q;

  // Next-state for the FIFO slots and the illegal counter; empty slots are kept at zero.
  always_comb begin
    new_s   = decode(bus.instr);
    push_s  = bus.in_valid && bus.in_ready;
    pop_s   = bus.out_ready && (count_q != 2'd0);
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    err_d   = err_q;
    if (bus.flush) begin
      head_d  = EMPTY_ENTRY;
      tail_d  = EMPTY_ENTRY;
      count_d = 2'd0;
    end else begin
      case (count_q)
        2'd0: begin
          if (push_s) begin
            head_d  = new_s;
            count_d = 2'd1;
          end else begin
            count_d = 2'd0;
          end
        end
        2'd1: begin
          if (push_s && pop_s) begin
            head_d = new_s;
          end else if (push_s) begin
            tail_d  = new_s;
            count_d = 2'd2;
          end else if (pop_s) begin
            head_d  = EMPTY_ENTRY;
            count_d = 2'd0;
          end else begin
            count_d = 2'd1;
          end
        end
        2'd2: begin
          if (pop_s) begin
            head_d  = tail_q;
            tail_d  = EMPTY_ENTRY;
            count_d = 2'd1;
          end else begin
            count_d = 2'd2;
          end
        end
        default: begin
          head_d  = EMPTY_ENTRY;
          tail_d  = EMPTY_ENTRY;
          count_d = 2'd0;
        end
      endcase
    end
    if (push_s && new_s.illegal && (err_q != ERR_MAX)) begin
      err_d = err_q + {{(ERR_W-1){1'b0}}, 1'b1};
    end else begin
      err_d = err_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= EMPTY_ENTRY;
      tail_q  <= EMPTY_ENTRY;
      count_q <= 2'd0;
      err_q   <= {ERR_W{1'b0}};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench: a 64-bit shifting instance and a 32-bit non-shifting
// instance receive identical stimulus and are checked against hand values.
module tb_imm_extend_pipe;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  imm_extend_pipe_if #(.N(64), .ERR_W(8)) bus64 ();
  imm_extend_pipe_if #(.N(32), .ERR_W(8)) bus32 ();

  imm_extend_pipe #(.N(64), .SHIFT_BRANCH(1'b1), .ERR_W(8)) dut64 (
    .clk(clk), .reset(reset), .bus(bus64)
  );
  imm_extend_pipe #(.N(32), .SHIFT_BRANCH(1'b0), .ERR_W(8)) dut32 (
    .clk(clk), .reset(reset), .bus(bus32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [31:0] ins, input logic fl, input logic rdy);
    bus64.in_valid = v;  bus32.in_valid = v;
    bus64.instr = ins;   bus32.instr = ins;
    bus64.flush = fl;    bus32.flush = fl;
    bus64.out_ready = rdy; bus32.out_ready = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step(); step();
    checks++; if ({bus64.out_valid, bus64.fmt, bus64.illegal, bus64.in_ready} !== 6'b0) begin failures++; $display("FAIL reset_flags actual=%b expected=000000", {bus64.out_valid, bus64.fmt, bus64.illegal, bus64.in_ready}); end
    checks++; if (bus64.imm !== 64'h0) begin failures++; $display("FAIL reset_imm actual=%h expected=0", bus64.imm); end
    checks++; if (bus64.err_count !== 8'h0) begin failures++; $display("FAIL reset_err actual=%h expected=0", bus64.err_count); end
    reset = 1'b0;
    #1;
    checks++; if (bus64.in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready actual=%b expected=1", bus64.in_ready); end
  endtask

  task automatic test_d_format();
    drive(1'b1, 32'hF85FF000, 1'b0, 1'b1);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    checks++; if ({bus64.out_valid, bus64.fmt, bus64.illegal} !== 5'b1_001_0) begin failures++; $display("FAIL d_fmt actual=%b expected=10010", {bus64.out_valid, bus64.fmt, bus64.illegal}); end
    checks++; if (bus64.imm !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL d_imm64 actual=%h expected=ffffffffffffffff", bus64.imm); end
    checks++; if (bus32.imm !== 32'hFFFF_FFFF) begin failures++; $display("FAIL d_imm32 actual=%h expected=ffffffff", bus32.imm); end
    step();
    checks++; if (bus64.out_valid !== 1'b0) begin failures++; $display("FAIL d_drained actual=%b expected=0", bus64.out_valid); end
  endtask

  task automatic test_cb_b_back_to_back();
    drive(1'b1, 32'hB4000020, 1'b0, 1'b1);
    step();
    drive(1'b1, 32'h16000000, 1'b0, 1'b1);
    checks++; if (bus64.imm !== 64'h4 || bus64.fmt !== 3'd2) begin failures++; $display("FAIL cb_imm64 actual=%h/%0d expected=4/2", bus64.imm, bus64.fmt); end
    checks++; if (bus32.imm !== 32'h1 || bus32.fmt !== 3'd2) begin failures++; $display("FAIL cb_imm32_noshift actual=%h/%0d expected=1/2", bus32.imm, bus32.fmt); end
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    checks++; if (bus64.imm !== 64'hFFFF_FFFF_F800_0000 || bus64.fmt !== 3'd3) begin failures++; $display("FAIL b_imm64 actual=%h/%0d expected=fffffffff8000000/3", bus64.imm, bus64.fmt); end
    checks++; if (bus32.imm !== 32'hFE00_0000 || bus32.fmt !== 3'd3) begin failures++; $display("FAIL b_imm32_noshift actual=%h/%0d expected=fe000000/3", bus32.imm, bus32.fmt); end
    step();
    checks++; if (bus64.out_valid !== 1'b0) begin failures++; $display("FAIL cb_b_drained actual=%b expected=0", bus64.out_valid); end
  endtask

  task automatic test_i_iw();
    drive(1'b1, 32'h913FFC00, 1'b0, 1'b1);
    step();
    drive(1'b1, 32'hD2F7DDE0, 1'b0, 1'b1);
    checks++; if (bus64.imm !== 64'h0FFF || bus64.fmt !== 3'd4) begin failures++; $display("FAIL i_imm64 actual=%h/%0d expected=fff/4", bus64.imm, bus64.fmt); end
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    checks++; if (bus64.imm !== 64'hBEEF_0000_0000_0000 || bus64.fmt !== 3'd5) begin failures++; $display("FAIL iw_imm64 actual=%h/%0d expected=beef000000000000/5", bus64.imm, bus64.fmt); end
    checks++; if (bus32.imm !== 32'h0 || bus32.fmt !== 3'd5) begin failures++; $display("FAIL iw_imm32 actual=%h/%0d expected=0/5", bus32.imm, bus32.fmt); end
    step();
  endtask

  task automatic test_illegal_single();
    drive(1'b1, 32'h00000000, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    checks++; if ({bus64.out_valid, bus64.fmt, bus64.illegal} !== 5'b1_000_1) begin failures++; $display("FAIL illegal_flags actual=%b expected=10001", {bus64.out_valid, bus64.fmt, bus64.illegal}); end
    checks++; if (bus64.imm !== 64'h0) begin failures++; $display("FAIL illegal_imm actual=%h expected=0", bus64.imm); end
    checks++; if (bus64.err_count !== 8'd1) begin failures++; $display("FAIL illegal_err actual=%0d expected=1", bus64.err_count); end
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    step();
  endtask

  task automatic test_backpressure();
    drive(1'b1, 32'hF85FF000, 1'b0, 1'b0);
    step();
    checks++; if (bus64.in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_one actual=%b expected=1", bus64.in_ready); end
    drive(1'b1, 32'hB4000020, 1'b0, 1'b0);
    step();
    checks++; if (bus64.in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_full actual=%b expected=0", bus64.in_ready); end
    drive(1'b1, 32'h913FFC00, 1'b0, 1'b0);
    step();
    checks++; if (bus64.fmt !== 3'd1 || bus64.imm !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL bp_hold_a actual=%h/%0d expected=ffffffffffffffff/1", bus64.imm, bus64.fmt); end
    drive(1'b1, 32'h913FFC00, 1'b0, 1'b1);
    step();
    checks++; if (bus64.fmt !== 3'd2 || bus64.imm !== 64'h4) begin failures++; $display("FAIL bp_order_b actual=%h/%0d expected=4/2", bus64.imm, bus64.fmt); end
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    checks++; if (bus64.fmt !== 3'd4 || bus64.imm !== 64'hFFF) begin failures++; $display("FAIL bp_order_c actual=%h/%0d expected=fff/4", bus64.imm, bus64.fmt); end
    step();
    checks++; if (bus64.out_valid !== 1'b0) begin failures++; $display("FAIL bp_no_dup actual=%b expected=0", bus64.out_valid); end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'hF85FF000, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'hB4000020, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h00000000, 1'b1, 1'b0);
    #1;
    checks++; if (bus64.in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready actual=%b expected=0", bus64.in_ready); end
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    checks++; if ({bus64.out_valid, bus64.fmt, bus64.illegal} !== 5'b0 || bus64.imm !== 64'h0) begin failures++; $display("FAIL flush_empty actual=%b/%h expected=00000/0", {bus64.out_valid, bus64.fmt, bus64.illegal}, bus64.imm); end
    checks++; if (bus64.err_count !== 8'd1) begin failures++; $display("FAIL flush_err_kept actual=%0d expected=1", bus64.err_count); end
    step();
    checks++; if (bus64.out_valid !== 1'b0) begin failures++; $display("FAIL flush_input_dropped actual=%b expected=0", bus64.out_valid); end
  endtask

  task automatic test_reset_full();
    drive(1'b1, 32'hF85FF000, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'hB4000020, 1'b0, 1'b0);
    step();
    reset = 1'b1;
    drive(1'b1, 32'h913FFC00, 1'b0, 1'b0);
    step();
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    checks++; if ({bus64.out_valid, bus64.fmt, bus64.illegal} !== 5'b0 || bus64.imm !== 64'h0 || bus64.err_count !== 8'h0) begin failures++; $display("FAIL reset_full_outputs actual=%b/%h/%0d expected=00000/0/0", {bus64.out_valid, bus64.fmt, bus64.illegal}, bus64.imm, bus64.err_count); end
    step();
    checks++; if (bus64.out_valid !== 1'b0) begin failures++; $display("FAIL reset_input_dropped actual=%b expected=0", bus64.out_valid); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 254; i++) begin
      drive(1'b1, 32'h00000000, 1'b0, 1'b1);
      step();
    end
    checks++; if (bus64.err_count !== 8'd254) begin failures++; $display("FAIL sat_pre actual=%0d expected=254", bus64.err_count); end
    for (int i = 0; i < 46; i++) begin
      drive(1'b1, 32'h00000000, 1'b0, 1'b1);
      step();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    checks++; if (bus64.err_count !== 8'd255) begin failures++; $display("FAIL sat_final actual=%0d expected=255", bus64.err_count); end
    step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_d_format();
    test_cb_b_back_to_back();
    test_i_iw();
    test_illegal_single();
    test_backpressure();
    test_flush();
    test_reset_full();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
